// File: rtl/alu_seq_hw2.sv
// Registered ALU with valid/ready handshakes on both sides and an iterative
// shift-add multiplier; one operation in flight at a time.
module alu_seq_hw2 #(
    parameter int unsigned WIDTH  = 3,
    parameter int unsigned MUL_EN = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] din0,
    input  logic [WIDTH-1:0] din1,
    input  logic [2:0]       op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] dout,
    output logic             carry,
    output logic             zero
);

    localparam int unsigned CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

    state_e           state_q;
    logic [WIDTH-1:0] mcand_q;
    logic [WIDTH-1:0] mplier_q;
    logic [WIDTH-1:0] acc_q;
    logic [CW-1:0]    cnt_q;

    logic [WIDTH:0]   alu_res;
    logic [WIDTH-1:0] acc_next;
    logic             is_mul;

    assign in_ready = (state_q == StIdle);
    assign is_mul   = (MUL_EN != 0) && (op == 3'd7);

    // Single-cycle result; top bit is the carry/not-borrow for ADD/SUB only.
    always_comb begin
        alu_res = '0;
        case (op)
            3'd0:    alu_res = {1'b0, din0} + {1'b0, din1};
            3'd1:    alu_res = {1'b0, din0} + {1'b0, ~din1} + {{WIDTH{1'b0}}, 1'b1};
            3'd2:    alu_res = {1'b0, din0 & din1};
            3'd3:    alu_res = {2'b00, din0[WIDTH-1:1]};
            3'd4:    alu_res = {1'b0, din0 | din1};
            3'd5:    alu_res = {1'b0, din0 ^ din1};
            3'd6:    alu_res = {1'b0, din0[WIDTH-2:0], 1'b0};
            default: alu_res = '0;
        endcase
    end

    assign acc_next = acc_q + (mplier_q[0] ? mcand_q : {WIDTH{1'b0}});

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            out_valid <= 1'b0;
            dout      <= '0;
            carry     <= 1'b0;
            zero      <= 1'b0;
            mcand_q   <= '0;
            mplier_q  <= '0;
            acc_q     <= '0;
            cnt_q     <= '0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (in_valid) begin
                        if (is_mul) begin
                            state_q  <= StBusy;
                            mcand_q  <= din0;
                            mplier_q <= din1;
                            acc_q    <= '0;
                            cnt_q    <= CW'(WIDTH);
                        end else begin
                            state_q   <= StDone;
                            out_valid <= 1'b1;
                            dout      <= alu_res[WIDTH-1:0];
                            carry     <= alu_res[WIDTH];
                            zero      <= (alu_res[WIDTH-1:0] == '0);
                        end
                    end
                end
                StBusy: begin
                    // One multiplier bit per cycle, LSB first; product kept mod 2^WIDTH.
                    acc_q    <= acc_next;
                    mcand_q  <= {mcand_q[WIDTH-2:0], 1'b0};
                    mplier_q <= {1'b0, mplier_q[WIDTH-1:1]};
                    cnt_q    <= cnt_q - CW'(1);
                    if (cnt_q == CW'(1)) begin
                        state_q   <= StDone;
                        out_valid <= 1'b1;
                        dout      <= acc_next;
                        carry     <= 1'b0;
                        zero      <= (acc_next == '0);
                    end
                end
                StDone: begin
                    if (out_ready) begin
                        state_q   <= StIdle;
                        out_valid <= 1'b0;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_seq_hw2.sv
// Directed, table-driven bench for alu_seq_hw2 (WIDTH=3), with a second
// instance built with MUL_EN=0 for the op-7 fallback.
module tb_alu_seq_hw2;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid, in_ready, out_valid, out_ready, carry, zero;
    logic [2:0] din0, din1, op, dout;

    logic       in_valid0, in_ready0, out_valid0, out_ready0, carry0, zero0;
    logic [2:0] dout0;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    alu_seq_hw2 #(.WIDTH(3), .MUL_EN(1)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .din0(din0), .din1(din1), .op(op), .out_valid(out_valid),
        .out_ready(out_ready), .dout(dout), .carry(carry), .zero(zero)
    );

    alu_seq_hw2 #(.WIDTH(3), .MUL_EN(0)) dut0 (
        .clk(clk), .rst(rst), .in_valid(in_valid0), .in_ready(in_ready0),
        .din0(din0), .din1(din1), .op(op), .out_valid(out_valid0),
        .out_ready(out_ready0), .dout(dout0), .carry(carry0), .zero(zero0)
    );

    typedef struct {
        string      name;
        logic [2:0] op;
        logic [2:0] a;
        logic [2:0] b;
        logic [2:0] d;
        logic       c;
        logic       z;
        int         lat;   // edges after the accept edge before out_valid is seen
    } vec_t;

    vec_t vecs[12];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_vec(input vec_t v);
        int n;
        din0     = v.a;
        din1     = v.b;
        op       = v.op;
        in_valid = 1'b1;
        check({v.name, " in_ready before"}, in_ready, 1);
        tick();
        in_valid = 1'b0;
        n = 0;
        while (!out_valid && n < 20) begin
            check({v.name, " in_ready busy"}, in_ready, 0);
            tick();
            n++;
        end
        check({v.name, " latency"}, n, v.lat);
        check({v.name, " dout"}, dout, v.d);
        check({v.name, " carry"}, carry, v.c);
        check({v.name, " zero"}, zero, v.z);
        check({v.name, " in_ready done"}, in_ready, 0);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check({v.name, " out_valid cleared"}, out_valid, 0);
        check({v.name, " in_ready back"}, in_ready, 1);
    endtask

    initial begin
        vecs[0]  = '{"add 5+6",  3'd0, 3'd5, 3'd6, 3'd3, 1'b1, 1'b0, 0};
        vecs[1]  = '{"sub 3-3",  3'd1, 3'd3, 3'd3, 3'd0, 1'b1, 1'b1, 0};
        vecs[2]  = '{"sub 2-5",  3'd1, 3'd2, 3'd5, 3'd5, 1'b0, 1'b0, 0};
        vecs[3]  = '{"srl1 6",   3'd3, 3'd6, 3'd0, 3'd3, 1'b0, 1'b0, 0};
        vecs[4]  = '{"sll1 6",   3'd6, 3'd6, 3'd0, 3'd4, 1'b0, 1'b0, 0};
        vecs[5]  = '{"xor 5^3",  3'd5, 3'd5, 3'd3, 3'd6, 1'b0, 1'b0, 0};
        vecs[6]  = '{"and 6&3",  3'd2, 3'd6, 3'd3, 3'd2, 1'b0, 1'b0, 0};
        vecs[7]  = '{"or 4|1",   3'd4, 3'd4, 3'd1, 3'd5, 1'b0, 1'b0, 0};
        vecs[8]  = '{"srl1 1",   3'd3, 3'd1, 3'd7, 3'd0, 1'b0, 1'b1, 0};
        vecs[9]  = '{"mul 3*5",  3'd7, 3'd3, 3'd5, 3'd7, 1'b0, 1'b0, 3};
        vecs[10] = '{"mul 0*7",  3'd7, 3'd0, 3'd7, 3'd0, 1'b0, 1'b1, 3};
        vecs[11] = '{"mul 7*7",  3'd7, 3'd7, 3'd7, 3'd1, 1'b0, 1'b0, 3};

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        in_valid0 = 1'b0; out_ready0 = 1'b0;
        din0 = '0; din1 = '0; op = '0;
        tick();
        tick();
        check("reset out_valid", out_valid, 0);
        check("reset dout", dout, 0);
        check("reset carry", carry, 0);
        check("reset zero", zero, 0);
        check("reset in_ready", in_ready, 1);
        rst = 1'b0;

        for (int i = 0; i < 12; i++) run_vec(vecs[i]);

        // Backpressure: result held, stray in_valid pulses ignored.
        din0 = 3'd1; din1 = 3'd1; op = 3'd0; in_valid = 1'b1;
        tick();
        for (int i = 0; i < 5; i++) begin
            din0 = 3'(i + 2); din1 = 3'd4; in_valid = (i % 2 == 0);
            check("bp out_valid", out_valid, 1);
            check("bp dout", dout, 2);
            check("bp in_ready", in_ready, 0);
            tick();
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("bp release out_valid", out_valid, 0);
        check("bp release in_ready", in_ready, 1);
        tick();
        check("bp no ghost op", out_valid, 0);

        // Reset during the second BUSY cycle of a MUL.
        din0 = 3'd3; din1 = 3'd5; op = 3'd7; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mid-busy reset in_ready", in_ready, 1);
        check("mid-busy reset out_valid", out_valid, 0);
        for (int i = 0; i < 6; i++) begin
            check("mid-busy no output", out_valid, 0);
            tick();
        end
        run_vec('{"add 1+2 after reset", 3'd0, 3'd1, 3'd2, 3'd3, 1'b0, 1'b0, 0});

        // MUL_EN=0: op 7 is a single-cycle zero result.
        din0 = 3'd5; din1 = 3'd3; op = 3'd7; in_valid0 = 1'b1;
        check("nomul in_ready before", in_ready0, 1);
        tick();
        in_valid0 = 1'b0;
        check("nomul out_valid", out_valid0, 1);
        check("nomul dout", dout0, 0);
        check("nomul carry", carry0, 0);
        check("nomul zero", zero0, 1);
        out_ready0 = 1'b1;
        tick();
        out_ready0 = 1'b0;
        check("nomul out_valid cleared", out_valid0, 0);
        check("nomul in_ready back", in_ready0, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
